// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the core, loader and data-memory port signals around the arbiter.
// slave is the arbiter's view; master is the view of the surrounding system.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) ();
    logic              c_req;
    logic              c_we;
    logic              c_lock;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              l_req;
    logic              l_we;
    logic              l_lock;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_rvalid;
    logic [DATA_W-1:0] l_rdata;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  c_req, c_we, c_lock, c_addr, c_wdata,
        output c_gnt, c_rvalid, c_rdata,
        input  l_req, l_we, l_lock, l_addr, l_wdata,
        output l_gnt, l_rvalid, l_rdata,
        output m_en, m_we, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output c_req, c_we, c_lock, c_addr, c_wdata,
        input  c_gnt, c_rvalid, c_rdata,
        output l_req, l_we, l_lock, l_addr, l_wdata,
        input  l_gnt, l_rvalid, l_rdata,
        input  m_en, m_we, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between core (C) and loader (L),
// with a bounded grant lock and 1-cycle read-data return routing.
module dmem_port_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    dmem_port_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);

    typedef enum logic [1:0] {OWN_NONE, OWN_C, OWN_L} owner_e;

    logic             last_l_q, last_l_d;
    owner_e           lock_owner_q, lock_owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             c_rvalid_q, c_rvalid_d;
    logic             l_rvalid_q, l_rvalid_d;

    logic   c_hold, l_hold, c_win, l_win, any_gnt;
    owner_e win_owner;

    // A lock only holds while the other side is idle or the burst budget remains.
    always_comb begin
        c_hold = (lock_owner_q == OWN_C) && bus.c_req && (!bus.l_req || (burst_cnt_q < CNT_MAX));
        l_hold = (lock_owner_q == OWN_L) && bus.l_req && (!bus.c_req || (burst_cnt_q < CNT_MAX));
        c_win  = 1'b0;
        l_win  = 1'b0;
        if (c_hold) begin
            c_win = 1'b1;
        end else if (l_hold) begin
            l_win = 1'b1;
        end else if (bus.c_req && bus.l_req) begin
            c_win = last_l_q;
            l_win = !last_l_q;
        end else begin
            c_win = bus.c_req;
            l_win = bus.l_req;
        end
    end

    // Grants are gated by reset so nothing reaches the RAM while reset is held.
    assign bus.c_gnt = c_win & reset;
    assign bus.l_gnt = l_win & reset;
    assign any_gnt   = bus.c_gnt | bus.l_gnt;
    assign win_owner = bus.c_gnt ? OWN_C : OWN_L;

    assign bus.m_en    = any_gnt;
    assign bus.m_we    = bus.c_gnt ? bus.c_we    : (bus.l_gnt & bus.l_we);
    assign bus.m_addr  = bus.c_gnt ? bus.c_addr  : (bus.l_gnt ? bus.l_addr  : '0);
    assign bus.m_wdata = bus.c_gnt ? bus.c_wdata : (bus.l_gnt ? bus.l_wdata : '0);

    assign bus.c_rvalid = c_rvalid_q;
    assign bus.l_rvalid = l_rvalid_q;
    assign bus.c_rdata  = bus.m_rdata;
    assign bus.l_rdata  = bus.m_rdata;

    always_comb begin
        last_l_d     = last_l_q;
        lock_owner_d = OWN_NONE;
        burst_cnt_d  = '0;
        c_rvalid_d   = bus.c_gnt & ~bus.c_we;
        l_rvalid_d   = bus.l_gnt & ~bus.l_we;
        if (any_gnt) begin
            last_l_d = bus.l_gnt;
            if (bus.c_gnt && bus.c_lock) lock_owner_d = OWN_C;
            if (bus.l_gnt && bus.l_lock) lock_owner_d = OWN_L;
            // Counter saturates; it only has to tell "budget used up" from "not yet".
            if (lock_owner_q == win_owner) begin
                burst_cnt_d = (burst_cnt_q < CNT_MAX) ? burst_cnt_q + CNT_W'(1) : burst_cnt_q;
            end else begin
                burst_cnt_d = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_l_q     <= 1'b1;
            lock_owner_q <= OWN_NONE;
            burst_cnt_q  <= '0;
            c_rvalid_q   <= 1'b0;
            l_rvalid_q   <= 1'b0;
        end else begin
            last_l_q     <= last_l_d;
            lock_owner_q <= lock_owner_d;
            burst_cnt_q  <= burst_cnt_d;
            c_rvalid_q   <= c_rvalid_d;
            l_rvalid_q   <= l_rvalid_d;
        end
    end
endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Shares the single-port 4096x32 data memory between two requesters: the processor load/store path (requester C) and the program/data loader used for boot and debug (requester L). Per-cycle round-robin arbitration, with an optional bounded lock for loader or core bursts. The block drives the memory port and routes 1-cycle-latency read data back to the requester that issued the read. It sits between the processor core, the loader and the data RAM.

Parameters:
ADDR_W, 12, data memory word-address width (4096 words)
DATA_W, 32, data word width
BURST_MAX, 4, max consecutive locked grants to one requester while the other waits (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
c_req  input  1  core access request; held until c_gnt
c_we  input  1  core write enable (1 = store, 0 = load)
c_lock  input  1  core requests to keep the grant on the next cycle
c_addr  input  ADDR_W  core word address
c_wdata  input  DATA_W  core store data
c_gnt  output  1  core request accepted this cycle
c_rvalid  output  1  core read data valid
c_rdata  output  DATA_W  core read data
l_req, l_we, l_lock, l_addr, l_wdata  input  1/1/1/ADDR_W/DATA_W  loader request, same semantics as the core set
l_gnt  output  1  loader request accepted this cycle
l_rvalid  output  1  loader read data valid
l_rdata  output  DATA_W  loader read data
m_en  output  1  memory access strobe
m_we  output  1  memory write enable
m_addr  output  ADDR_W  memory word address
m_wdata  output  DATA_W  memory write data
m_rdata  input  DATA_W  memory read data, valid 1 cycle after an m_en & ~m_we access

Behaviour:
- Reset asserted (reset=0): c_rvalid=l_rvalid=0, last_owner=L (core wins the first tie), burst_cnt=0, lock_owner=none. c_gnt, l_gnt, m_en and m_we are forced to 0 while reset=0.
- Handshake: x_req is level-sensitive. x_we/x_addr/x_wdata stay stable while x_req=1 and x_gnt=0. A transfer occurs in any cycle with x_req & x_gnt. The requester may present the next request in the following cycle.
- Grant is combinational from requests and registered state. At most one gnt per cycle. gnt is never asserted without req.
- Grant selection, in priority order:
  - If lock_owner=X and X_req=1 and (other requester idle or burst_cnt < BURST_MAX), grant X.
  - Else if only one requester is active, grant it.
  - Else if both are active, grant the requester that is not last_owner.
- Memory port: m_en = c_gnt|l_gnt. m_we/m_addr/m_wdata are muxed from the granted requester. When m_en=0, m_we=0 and address/data are don't-care (drive 0).
- Registered on each granted cycle:
  - last_owner <= winner.
  - lock_owner <= winner if winner_lock=1, else none.
  - burst_cnt <= burst_cnt+1 if winner equals the previous winner and the previous grant was locked; otherwise burst_cnt <= 1.
- A cycle with no grant clears lock_owner and burst_cnt.
- Forced rotation: once BURST_MAX consecutive grants have gone to one owner while the other requester waited, the waiter wins the next cycle. Worst-case wait = BURST_MAX cycles.
- Read return latency is exactly 1 cycle: x_rvalid <= x_gnt & ~x_we. x_rdata = m_rdata for both requesters (qualified by x_rvalid). Writes produce no rvalid.
- Back-to-back reads from alternating requesters each get their own rvalid in consecutive cycles; no data loss.
- Address is used as-is (ADDR_W bits); no wrap logic. 0xFFF is a valid address.
- Reset asserted mid-operation: in-flight read response is discarded (rvalid cleared asynchronously). Lock and burst state are lost. After release, arbitration restarts with core priority.

Test Plan:
1. Release reset; core read c_addr=0x010, RAM[0x010]=0x00000055 -> c_gnt=1 same cycle, m_en=1, m_we=0, m_addr=0x010; next cycle c_rvalid=1, c_rdata=0x00000055, l_rvalid=0.
2. c_req=l_req=1 held, no locks, 6 cycles -> grants C,L,C,L,C,L; m_en=1 every cycle; rvalids follow the owner with 1-cycle delay.
3. BURST_MAX=4, l_lock=1 held, c_req=1 throughout -> l_gnt cycles 1-4, c_gnt cycle 5; the core waits exactly 4 cycles.
4. Loader write 0xABCD1234 to 0xFFF, then core read 0xFFF -> no rvalid for the write cycle; c_rvalid next cycle with 0xABCD1234.
5. Core read granted, reset driven low before the next edge -> c_rvalid=0 immediately; after release, simultaneous requests grant core first.
6. l_lock drops after 2 locked grants with core waiting -> core granted in the next cycle; burst_cnt restarts at 1.
